// File: rtl/syr2k_pkg.sv
// Shared constants and width helpers for the SYR2K element datapath.
// Widths track full-precision signed growth through each pipeline stage.
package syr2k_pkg;

    localparam int ALPHA_DEF = 32412;
    localparam int BETA_DEF  = 2123;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int sum_w(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int aterm_w(input int dw, input int cw);
        return 2 * dw + 1 + cw;
    endfunction

    function automatic int bterm_w(input int dw, input int cw);
        return dw + cw;
    endfunction

    function automatic int fin_w(input int dw, input int cw);
        int a;
        int b;
        a = aterm_w(dw, cw);
        b = bterm_w(dw, cw);
        return ((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/syr2k_sat_trunc.sv
// Reduces a wide signed value to OW bits, by wrapping or by clamping
// to the signed OW range.
module syr2k_sat_trunc
    import syr2k_pkg::*;
#(
    parameter int IW  = 82,
    parameter int OW  = 32,
    parameter int SAT = SAT_WRAP
) (
    input  logic [IW-1:0] d_i,
    output logic [OW-1:0] q_o
);

    logic [IW-OW:0] hi;
    logic           ovf;

    // Value fits when every bit from the OW sign position upward agrees.
    always_comb begin
        hi  = d_i[IW-1:OW-1];
        ovf = !((&hi) || !(|hi));
        q_o = d_i[OW-1:0];
        if (SAT == SAT_CLAMP && ovf) begin
            q_o = d_i[IW-1] ? {1'b1, {(OW-1){1'b0}}}
                            : {1'b0, {(OW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/syr2k_pe_pipe.sv
// Pipelined SYR2K element: cout = beta*Z + alpha*(X*YT + XT*Y).
// Three compute stages plus an output register, stalled as a whole.
module syr2k_pe_pipe
    import syr2k_pkg::*;
#(
    parameter int DW        = 32,
    parameter int CW        = 16,
    parameter int OW        = 32,
    parameter int SAT       = SAT_WRAP,
    parameter int ALPHA_RST = ALPHA_DEF,
    parameter int BETA_RST  = BETA_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_alpha,
    input  logic [CW-1:0] cfg_beta,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] z,
    input  logic [DW-1:0] xt,
    input  logic [DW-1:0] yt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] cout,
    output logic          busy
);

    localparam int PW = prod_w(DW);
    localparam int SW = sum_w(DW);
    localparam int BW = bterm_w(DW, CW);
    localparam int FW = fin_w(DW, CW);

    logic                 adv;
    logic signed [CW-1:0] alpha_q;
    logic signed [CW-1:0] beta_q;

    logic                 v1_q;
    logic                 v2_q;
    logic                 v3_q;
    logic                 ov_q;

    logic signed [PW-1:0] p0_q;
    logic signed [PW-1:0] p0_d;
    logic signed [PW-1:0] p1_q;
    logic signed [PW-1:0] p1_d;
    logic signed [BW-1:0] bz1_q;
    logic signed [BW-1:0] bz1_d;
    logic signed [CW-1:0] a1_q;

    logic signed [SW-1:0] s2_q;
    logic signed [SW-1:0] s2_d;
    logic signed [BW-1:0] bz2_q;
    logic signed [CW-1:0] a2_q;

    logic signed [FW-1:0] r3_q;
    logic signed [FW-1:0] r3_d;

    logic [OW-1:0]        cout_q;
    logic [OW-1:0]        cout_d;

    assign adv       = !ov_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign cout      = cout_q;
    assign busy      = v1_q || v2_q || v3_q;

    // Operands are sign-extended to the result width before each op.
    always_comb begin
        p0_d  = PW'($signed(x)) * PW'($signed(yt));
        p1_d  = PW'($signed(xt)) * PW'($signed(y));
        bz1_d = BW'(beta_q) * BW'($signed(z));
        s2_d  = SW'(p0_q) + SW'(p1_q);
        r3_d  = FW'(a2_q) * FW'(s2_q) + FW'(bz2_q);
    end

    syr2k_sat_trunc #(
        .IW  (FW),
        .OW  (OW),
        .SAT (SAT)
    ) u_red (
        .d_i (r3_q),
        .q_o (cout_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_q <= CW'(ALPHA_RST);
            beta_q  <= CW'(BETA_RST);
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            ov_q    <= 1'b0;
            p0_q    <= '0;
            p1_q    <= '0;
            bz1_q   <= '0;
            a1_q    <= '0;
            s2_q    <= '0;
            bz2_q   <= '0;
            a2_q    <= '0;
            r3_q    <= '0;
            cout_q  <= '0;
        end else begin
            // S1 samples alpha_q/beta_q before this edge's update lands.
            if (cfg_we) begin
                alpha_q <= cfg_alpha;
                beta_q  <= cfg_beta;
            end
            if (adv) begin
                v1_q   <= in_valid;
                p0_q   <= p0_d;
                p1_q   <= p1_d;
                bz1_q  <= bz1_d;
                a1_q   <= alpha_q;
                v2_q   <= v1_q;
                s2_q   <= s2_d;
                bz2_q  <= bz1_q;
                a2_q   <= a1_q;
                v3_q   <= v2_q;
                r3_q   <= r3_d;
                ov_q   <= v3_q;
                cout_q <= cout_d;
            end
        end
    end

endmodule

// File: tb/tb_syr2k_pe_pipe.sv
// Scoreboard bench for syr2k_pe_pipe: wrap and saturate instances share
// stimulus; a wide-integer model supplies the expected results.
module tb_syr2k_pe_pipe;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] xt;
        logic [31:0] yt;
    } beat_t;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_alpha = '0;
    logic [15:0] cfg_beta = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0, y = '0, z = '0, xt = '0, yt = '0;

    logic        in_ready0, out_valid0, busy0;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] cout0, cout1;

    int tests = 0;
    int fails = 0;

    exp_t        exp_q[$];
    logic [15:0] ma = 16'd32412;
    logic [15:0] mb = 16'd2123;

    always #5 clk = ~clk;

    syr2k_pe_pipe #(.SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .cfg_we(cfg_we),
        .cfg_alpha(cfg_alpha), .cfg_beta(cfg_beta),
        .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .y(y), .z(z), .xt(xt), .yt(yt),
        .out_valid(out_valid0), .out_ready(out_ready),
        .cout(cout0), .busy(busy0)
    );

    syr2k_pe_pipe #(.SAT(1)) u_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we),
        .cfg_alpha(cfg_alpha), .cfg_beta(cfg_beta),
        .in_valid(in_valid), .in_ready(in_ready1),
        .x(x), .y(y), .z(z), .xt(xt), .yt(yt),
        .out_valid(out_valid1), .out_ready(out_ready),
        .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input beat_t b, input logic [15:0] a,
                                   input logic [15:0] bt);
        logic signed [127:0] vx, vy, vz, vxt, vyt, va, vb, r;
        exp_t e;
        vx  = 128'($signed(b.x));
        vy  = 128'($signed(b.y));
        vz  = 128'($signed(b.z));
        vxt = 128'($signed(b.xt));
        vyt = 128'($signed(b.yt));
        va  = 128'($signed(a));
        vb  = 128'($signed(bt));
        r   = vb * vz + va * (vx * vyt + vxt * vy);
        e.w = r[31:0];
        if (r > 128'sh7FFF_FFFF)
            e.s = 32'h7FFF_FFFF;
        else if (r < -128'sh8000_0000)
            e.s = 32'h8000_0000;
        else
            e.s = r[31:0];
        return e;
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0)
            return 32'($urandom_range(0, 8)) - 32'd4;
        return $urandom;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.x  = rnd_word();
        b.y  = rnd_word();
        b.z  = rnd_word();
        b.xt = rnd_word();
        b.yt = rnd_word();
        return b;
    endfunction

    // One cycle: drive after posedge, record acceptance at negedge.
    task automatic step(input logic iv, input beat_t b, input logic ordy,
                        output logic acc);
        in_valid  = iv;
        x = b.x; y = b.y; z = b.z; xt = b.xt; yt = b.yt;
        out_ready = ordy;
        @(negedge clk);
        acc = iv && in_ready0 && !rst;
        if (rst) begin
            exp_q.delete();
            ma = 16'd32412;
            mb = 16'd2123;
        end else begin
            if (acc) exp_q.push_back(model(b, ma, mb));
            if (cfg_we) begin
                ma = cfg_alpha;
                mb = cfg_beta;
            end
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic drain();
        logic  acc;
        int    n;
        beat_t z0;
        z0 = '0;
        n  = 0;
        while ((exp_q.size() != 0 || busy0 || out_valid0) && n < 60) begin
            step(1'b0, z0, 1'b1, acc);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pop on each output transfer, and watch stall stability.
    logic        stall_seen = 1'b0;
    logic [31:0] stall_cout = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("stall_valid", 64'(out_valid0), 64'd1);
                chk("stall_cout", 64'(cout0), 64'(stall_cout));
            end
            if (out_valid0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out actual=%0h required=none",
                             cout0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cout_wrap", 64'(cout0), 64'(e.w));
                    chk("cout_sat", 64'(cout1), 64'(e.s));
                    chk("sat_valid", 64'(out_valid1), 64'd1);
                end
            end
            stall_seen = out_valid0 && !out_ready;
            stall_cout = cout0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    beat_t dir[$];
    beat_t bp[6];
    beat_t ones;

    initial begin
        logic acc;
        int   lat;
        int   nacc;
        int   n;
        logic found;
        beat_t b;

        ones = '{x: 32'd1, y: 32'd1, z: 32'd1, xt: 32'd1, yt: 32'd1};

        rst = 1'b1;
        step(1'b0, ones, 1'b1, acc);
        rst = 1'b1;
        step(1'b0, ones, 1'b1, acc);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_busy", 64'(busy0 | busy1), 64'd0);
        chk("rst_cout", 64'(cout0), 64'd0);
        chk("rst_in_ready", 64'({in_ready0, in_ready1}), 64'd3);
        @(posedge clk);
        #1;

        // Basic beat with latency measured in edges after acceptance.
        step(1'b1, ones, 1'b1, acc);
        chk("basic_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 10) begin
            @(negedge clk);
            if (out_valid0) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        @(posedge clk);
        #1;
        chk("latency", 64'(lat), 64'd3);
        drain();

        dir.push_back('{x: 32'hFFFF_FFFF, y: 0, z: 0, xt: 0, yt: 32'd1});
        dir.push_back('{x: 32'h0001_0000, y: 0, z: 0, xt: 0,
                        yt: 32'h0001_0000});
        dir.push_back('{x: 32'h7FFF_FFFF, y: 32'h7FFF_FFFF, z: 0,
                        xt: 32'h7FFF_FFFF, yt: 32'h7FFF_FFFF});
        dir.push_back('{x: 32'h8000_0001, y: 32'h7FFF_FFFF, z: 0,
                        xt: 32'h7FFF_FFFF, yt: 32'h7FFF_FFFF});
        dir.push_back('{x: 32'h8000_0001, y: 32'h7FFF_FFFF, z: 0,
                        xt: 32'h8000_0001, yt: 32'h7FFF_FFFF});
        dir.push_back('{x: 32'h8000_0000, y: 32'h8000_0000,
                        z: 32'h8000_0000, xt: 32'h8000_0000,
                        yt: 32'h8000_0000});
        foreach (dir[i]) step(1'b1, dir[i], 1'b1, acc);
        drain();

        // Backpressure: six offered beats, only four fit while stalled.
        for (int i = 0; i < 6; i++) bp[i] = rnd_beat();
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bp[nacc], 1'b0, acc);
            if (acc) nacc++;
        end
        chk("bp_absorbed", 64'(nacc), 64'd4);
        chk("bp_in_ready", 64'(in_ready0), 64'd0);
        n = 0;
        while (nacc < 6 && n < 20) begin
            step(1'b1, bp[nacc], 1'b1, acc);
            if (acc) nacc++;
            n++;
        end
        chk("bp_all_in", 64'(nacc), 64'd6);
        drain();

        // Coefficient update on the same edge as beat A.
        cfg_we = 1'b1;
        cfg_alpha = 16'd1;
        cfg_beta = 16'd0;
        step(1'b1, ones, 1'b1, acc);
        step(1'b1, ones, 1'b1, acc);
        drain();

        // Random traffic, random backpressure, occasional reprogramming.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_we = 1'b1;
                cfg_alpha = 16'($urandom);
                cfg_beta = 16'($urandom);
            end
            b = rnd_beat();
            step(1'($urandom_range(0, 9) < 7), b,
                 1'($urandom_range(0, 9) < 7), acc);
        end
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) step(1'b1, rnd_beat(), 1'b1, acc);
        rst = 1'b1;
        step(1'b0, ones, 1'b1, acc);
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid0), 64'd0);
        chk("mid_rst_busy", 64'(busy0), 64'd0);
        chk("mid_rst_cout", 64'(cout0), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) step(1'b0, ones, 1'b1, acc);
        step(1'b1, ones, 1'b1, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
